step_accumulator: RTL and testbench
===================================

Name: step_accumulator

Overview:
- Sits directly downstream of the neural step classifier and consumes its 1-bit `step` decision, one decision per sample strobe.
- Debounces the raw decision and enforces a refractory window, so one physical stride yields exactly one count.
- Accumulates strides into a saturating running total, preloadable from the stored `totalSteps`.
- Drives `updatedSteps` back to storage.

Parameters:
- WIDTH, 16, width of the step total.
- DEBOUNCE, 2, consecutive valid samples with step=1 required to confirm a stride (legal range >=1).
- REFRACT, 4, valid samples after stride release during which step is ignored (legal range >=0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- step  input  1  classifier decision (1 = stride-like sample).
- step_valid  input  1  qualifies `step`; asserted for one cycle per classified sample.
- load  input  1  loads `totalSteps` into the accumulator.
- totalSteps  input  WIDTH  preload value.
- updatedSteps  output  WIDTH  registered running total.
- step_pulse  output  1  one-cycle strobe when a stride is counted.
- saturated  output  1  sticky; set when an increment is attempted at all-ones.
- busy  output  1  high when FSM is not IDLE.

Behaviour:
Clocking and reset
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- On rst: updatedSteps=0, step_pulse=0, saturated=0, busy=0, FSM=IDLE, confirm counter=0, refractory counter=0.

Priority (highest first): rst > load > sample processing.
- load cycle: updatedSteps<=totalSteps, saturated<=0, FSM<=IDLE, counters<=0, step_pulse<=0.
- A step_valid arriving in the same cycle as load is dropped.

FSM
- Advances only on cycles with step_valid=1. With step_valid=0, state and counters hold and step_pulse=0.
- IDLE:
  - step=1 and DEBOUNCE=1: count the stride, go to HOLD.
  - step=1 and DEBOUNCE>1: confirm counter=1, go to CONFIRM.
  - step=0: stay in IDLE.
- CONFIRM:
  - step=1: increment confirm counter. When it reaches DEBOUNCE, count the stride and go to HOLD.
  - step=0: go to IDLE and clear the counter (glitch rejected, no count).
- HOLD: waits for step release.
  - step=0 and REFRACT=0: go to IDLE.
  - step=0 and REFRACT>0: go to REFRACT with refractory counter=0.
  - step=1: stay in HOLD. A long-held step counts once only.
- REFRACT:
  - Each valid sample increments the refractory counter; step is ignored.
  - When the counter reaches REFRACT, go to IDLE.
  - The first sample that can start a new confirmation is the one after the cycle that returns to IDLE.

Count action (registered)
- Applies in the cycle after the confirming sample: step_pulse=1 for exactly one cycle.
- If updatedSteps < 2^WIDTH-1: updatedSteps<=updatedSteps+1.
- Otherwise: updatedSteps holds at all-ones and saturated<=1. step_pulse still asserts.
- Latency: the confirming step_valid edge is followed one clock later by the visible updatedSteps and step_pulse.

Width and status rules
- updatedSteps wraps never: it is saturating.
- Counter widths are sized to hold DEBOUNCE and REFRACT; compare for equality, not overflow.
- busy is combinational from state (state != IDLE).

Reset mid-operation
- rst in any state returns everything to reset values on that edge.
- No partial stride survives reset or load.

Test Plan:
- Reset state: assert rst 2 cycles with step=1, step_valid=1 -> updatedSteps=0, step_pulse=0, busy=0 throughout and 1 cycle after release.
- Debounce and refractory (DEBOUNCE=2, REFRACT=4): load 100, then valid samples step=1,1,0,0,0,0,0 then 1,1 -> updatedSteps 101 one clock after 2nd sample, 102 after the 9th. step_pulse high exactly 2 cycles total.
- Glitch and long hold: valid samples step=1,0,1,0 -> no count. Step held 1 for 20 valid samples -> exactly one count. Samples with step_valid=0 between valid ones do not change state.
- Refractory rejection: stride counted, release, then step=1 on refractory samples 1-3 -> no count. busy stays high until 4th refractory sample.
- Saturation: WIDTH=16, load 0xFFFE, two confirmed strides -> 0xFFFF with saturated=0, then 0xFFFF with saturated=1 and step_pulse=1. A subsequent load of 5 clears saturated and outputs 5.
- Priority: load=1 with totalSteps=7 in the same cycle as the confirming sample -> updatedSteps=7, no step_pulse, FSM=IDLE. rst asserted in CONFIRM -> IDLE, updatedSteps=0.

Source files
------------

// File: rtl/step_accumulator_if.sv
// Bundles the classifier-side inputs and storage-side outputs of the step accumulator.
// The master drives the stimulus and the slave is the accumulator itself.
interface step_accumulator_if #(
    parameter int WIDTH = 16
) ();
    logic             step;
    logic             step_valid;
    logic             load;
    logic [WIDTH-1:0] totalSteps;
    logic [WIDTH-1:0] updatedSteps;
    logic             step_pulse;
    logic             saturated;
    logic             busy;

    modport master (
        output step, step_valid, load, totalSteps,
        input  updatedSteps, step_pulse, saturated, busy
    );

    modport slave (
        input  step, step_valid, load, totalSteps,
        output updatedSteps, step_pulse, saturated, busy
    );
endinterface

// File: rtl/step_accumulator.sv
// Debounces the classifier's step decision, applies a refractory window after each stride,
// and keeps a saturating, preloadable stride total that is written back to storage.
module step_accumulator #(
    parameter int WIDTH    = 16,
    parameter int DEBOUNCE = 2,
    parameter int REFRACT  = 4
) (
    input logic               clk,
    input logic               rst,
    step_accumulator_if.slave bus
);

    localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
    localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE);
    localparam logic [RW-1:0] REF_C = RW'(REFRACT);

    typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HOLD, S_REFRACT} state_t;

    state_t           state_q;
    logic [CW-1:0]    confirm_q;
    logic [RW-1:0]    refract_q;
    logic [WIDTH-1:0] total_q;
    logic             pulse_q;
    logic             sat_q;

    logic [WIDTH-1:0] total_d;
    logic             sat_d;

    // Result of counting one stride: increment, or pin at all-ones and flag saturation.
    always_comb begin
        total_d = total_q;
        sat_d   = sat_q;
        if (total_q == '1) begin
            sat_d = 1'b1;
        end else begin
            total_d = total_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            confirm_q <= '0;
            refract_q <= '0;
            total_q   <= '0;
            pulse_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else if (bus.load) begin
            state_q   <= S_IDLE;
            confirm_q <= '0;
            refract_q <= '0;
            total_q   <= bus.totalSteps;
            pulse_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.step_valid) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.step) begin
                            if (DEB_C == CW'(1)) begin
                                total_q <= total_d;
                                sat_q   <= sat_d;
                                pulse_q <= 1'b1;
                                state_q <= S_HOLD;
                            end else begin
                                confirm_q <= CW'(1);
                                state_q   <= S_CONFIRM;
                            end
                        end
                    end
                    S_CONFIRM: begin
                        if (bus.step) begin
                            if (confirm_q + 1'b1 == DEB_C) begin
                                total_q   <= total_d;
                                sat_q     <= sat_d;
                                pulse_q   <= 1'b1;
                                confirm_q <= '0;
                                state_q   <= S_HOLD;
                            end else begin
                                confirm_q <= confirm_q + 1'b1;
                            end
                        end else begin
                            confirm_q <= '0;
                            state_q   <= S_IDLE;
                        end
                    end
                    S_HOLD: begin
                        // A held step stays here so a long stride is counted once.
                        if (!bus.step) begin
                            if (REFRACT == 0) begin
                                state_q <= S_IDLE;
                            end else begin
                                refract_q <= '0;
                                state_q   <= S_REFRACT;
                            end
                        end
                    end
                    S_REFRACT: begin
                        if (refract_q + 1'b1 == REF_C) begin
                            refract_q <= '0;
                            state_q   <= S_IDLE;
                        end else begin
                            refract_q <= refract_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.updatedSteps = total_q;
    assign bus.step_pulse   = pulse_q;
    assign bus.saturated    = sat_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_step_accumulator.sv
// Table-driven check of step_accumulator with DEBOUNCE=2, REFRACT=4: each vector's
// expected outputs are queued when it is driven and compared one clock later.
module tb_step_accumulator;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst;

    step_accumulator_if #(.WIDTH(WIDTH)) accIf ();

    step_accumulator #(
        .WIDTH   (WIDTH),
        .DEBOUNCE(2),
        .REFRACT (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(accIf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             load;
        logic [WIDTH-1:0] total;
        logic             sv;
        logic             st;
        logic [WIDTH-1:0] expUpd;
        logic             expPulse;
        logic             expSat;
        logic             expBusy;
        int               tag;
    } vec_t;

    vec_t  tbl[$];
    vec_t  expQ[$];
    int    applied     = 0;
    int    miscompares = 0;
    int    vecIdx      = 0;
    string phaseName[7] = '{"reset", "debounce", "glitch", "longhold", "refract", "saturate", "priority"};

    function automatic void add(input int tag, input logic r, input logic ld, input logic [WIDTH-1:0] tot,
                                input logic sv, input logic st, input logic [WIDTH-1:0] upd,
                                input logic pulse, input logic sat, input logic busy);
        vec_t v;
        v.rst = r; v.load = ld; v.total = tot; v.sv = sv; v.st = st;
        v.expUpd = upd; v.expPulse = pulse; v.expSat = sat; v.expBusy = busy; v.tag = tag;
        tbl.push_back(v);
    endfunction

    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard vec %0d: got empty expectation queue, want one entry", vecIdx);
            return;
        end
        e = expQ.pop_front();
        applied++;
        if (accIf.updatedSteps !== e.expUpd || accIf.step_pulse !== e.expPulse ||
            accIf.saturated !== e.expSat || accIf.busy !== e.expBusy) begin
            miscompares++;
            $display("[TB] FAIL %s vec %0d: got upd=%h pulse=%b sat=%b busy=%b, want upd=%h pulse=%b sat=%b busy=%b",
                     phaseName[e.tag], vecIdx, accIf.updatedSteps, accIf.step_pulse, accIf.saturated,
                     accIf.busy, e.expUpd, e.expPulse, e.expSat, e.expBusy);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst                = v.rst;
        accIf.load         = v.load;
        accIf.totalSteps   = v.total;
        accIf.step_valid   = v.sv;
        accIf.step         = v.st;
        expQ.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst              = 1'b1;
        accIf.load       = 1'b0;
        accIf.totalSteps = '0;
        accIf.step_valid = 1'b0;
        accIf.step       = 1'b0;

        //  tag r  ld tot       sv st  upd       pl sat busy
        add(0, 1, 0, 16'd0,    1, 1, 16'd0,    0, 0, 0);
        add(0, 1, 0, 16'd0,    1, 1, 16'd0,    0, 0, 0);
        add(0, 0, 0, 16'd0,    0, 0, 16'd0,    0, 0, 0);

        add(1, 0, 1, 16'd100,  0, 0, 16'd100,  0, 0, 0);
        add(1, 0, 0, 16'd0,    1, 1, 16'd100,  0, 0, 1);
        add(1, 0, 0, 16'd0,    1, 1, 16'd101,  1, 0, 1);
        add(1, 0, 0, 16'd0,    1, 0, 16'd101,  0, 0, 1);
        add(1, 0, 0, 16'd0,    1, 0, 16'd101,  0, 0, 1);
        add(1, 0, 0, 16'd0,    1, 0, 16'd101,  0, 0, 1);
        add(1, 0, 0, 16'd0,    1, 0, 16'd101,  0, 0, 1);
        add(1, 0, 0, 16'd0,    1, 0, 16'd101,  0, 0, 0);
        add(1, 0, 0, 16'd0,    1, 1, 16'd101,  0, 0, 1);
        add(1, 0, 0, 16'd0,    1, 1, 16'd102,  1, 0, 1);

        add(2, 0, 1, 16'd50,   0, 0, 16'd50,   0, 0, 0);
        add(2, 0, 0, 16'd0,    1, 1, 16'd50,   0, 0, 1);
        add(2, 0, 0, 16'd0,    1, 0, 16'd50,   0, 0, 0);
        add(2, 0, 0, 16'd0,    1, 1, 16'd50,   0, 0, 1);
        add(2, 0, 0, 16'd0,    1, 0, 16'd50,   0, 0, 0);
        add(2, 0, 0, 16'd0,    1, 1, 16'd50,   0, 0, 1);
        add(2, 0, 0, 16'd0,    0, 1, 16'd50,   0, 0, 1);
        add(2, 0, 0, 16'd0,    0, 0, 16'd50,   0, 0, 1);
        add(2, 0, 0, 16'd0,    1, 1, 16'd51,   1, 0, 1);

        add(3, 0, 1, 16'd0,    0, 0, 16'd0,    0, 0, 0);
        add(3, 0, 0, 16'd0,    1, 1, 16'd0,    0, 0, 1);
        add(3, 0, 0, 16'd0,    1, 1, 16'd1,    1, 0, 1);
        for (int i = 0; i < 18; i++) begin
            add(3, 0, 0, 16'd0, 1, 1, 16'd1, 0, 0, 1);
        end
        add(3, 0, 0, 16'd0,    1, 0, 16'd1,    0, 0, 1);

        add(4, 0, 1, 16'd10,   0, 0, 16'd10,   0, 0, 0);
        add(4, 0, 0, 16'd0,    1, 1, 16'd10,   0, 0, 1);
        add(4, 0, 0, 16'd0,    1, 1, 16'd11,   1, 0, 1);
        add(4, 0, 0, 16'd0,    1, 0, 16'd11,   0, 0, 1);
        add(4, 0, 0, 16'd0,    1, 1, 16'd11,   0, 0, 1);
        add(4, 0, 0, 16'd0,    1, 1, 16'd11,   0, 0, 1);
        add(4, 0, 0, 16'd0,    1, 1, 16'd11,   0, 0, 1);
        add(4, 0, 0, 16'd0,    1, 1, 16'd11,   0, 0, 0);
        add(4, 0, 0, 16'd0,    1, 1, 16'd11,   0, 0, 1);
        add(4, 0, 0, 16'd0,    1, 1, 16'd12,   1, 0, 1);

        add(5, 0, 1, 16'hFFFE, 0, 0, 16'hFFFE, 0, 0, 0);
        add(5, 0, 0, 16'd0,    1, 1, 16'hFFFE, 0, 0, 1);
        add(5, 0, 0, 16'd0,    1, 1, 16'hFFFF, 1, 0, 1);
        add(5, 0, 0, 16'd0,    1, 0, 16'hFFFF, 0, 0, 1);
        add(5, 0, 0, 16'd0,    1, 0, 16'hFFFF, 0, 0, 1);
        add(5, 0, 0, 16'd0,    1, 0, 16'hFFFF, 0, 0, 1);
        add(5, 0, 0, 16'd0,    1, 0, 16'hFFFF, 0, 0, 1);
        add(5, 0, 0, 16'd0,    1, 0, 16'hFFFF, 0, 0, 0);
        add(5, 0, 0, 16'd0,    1, 1, 16'hFFFF, 0, 0, 1);
        add(5, 0, 0, 16'd0,    1, 1, 16'hFFFF, 1, 1, 1);
        add(5, 0, 0, 16'd0,    1, 0, 16'hFFFF, 0, 1, 1);
        add(5, 0, 1, 16'd5,    0, 0, 16'd5,    0, 0, 0);

        add(6, 0, 1, 16'd20,   0, 0, 16'd20,   0, 0, 0);
        add(6, 0, 0, 16'd0,    1, 1, 16'd20,   0, 0, 1);
        add(6, 0, 1, 16'd7,    1, 1, 16'd7,    0, 0, 0);
        add(6, 0, 0, 16'd0,    1, 1, 16'd7,    0, 0, 1);
        add(6, 1, 0, 16'd0,    1, 1, 16'd0,    0, 0, 0);
        add(6, 0, 0, 16'd0,    1, 1, 16'd0,    0, 0, 1);
        add(6, 1, 1, 16'd9,    1, 1, 16'd0,    0, 0, 0);
        add(6, 0, 0, 16'd0,    0, 0, 16'd0,    0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            vecIdx = i;
            applyStimulus(tbl[i]);
        end

        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d leftover entries, want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
